// File: rtl/vblank_scheduler.sv
// Frame-level sequencer: on each rising edge of vblnk it starts every enabled
// update client in index order, waits for its done and enforces a per-client timeout.
module vblank_scheduler #(
    parameter int N_CLIENTS = 4,
    parameter int TIMEOUT   = 4096,
    parameter int FRAME_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 vblnk,
    input  logic [N_CLIENTS-1:0] client_en,
    input  logic [N_CLIENTS-1:0] client_done,
    input  logic                 err_clr,
    output logic [N_CLIENTS-1:0] client_start,
    output logic [((N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1)-1:0] active_client,
    output logic                 busy,
    output logic                 frame_tick,
    output logic [FRAME_W-1:0]   frame_cnt,
    output logic                 overrun,
    output logic [N_CLIENTS-1:0] timeout_flags
);

    localparam int AW = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;
    localparam int IW = $clog2(N_CLIENTS + 1);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [IW-1:0] IDX_END  = IW'(N_CLIENTS);
    localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SELECT = 2'd1,
        ST_START  = 2'd2,
        ST_WAIT   = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic                 vblnk_q;
    logic                 frame_tick_q, frame_tick_d;
    logic [FRAME_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic                 overrun_q, overrun_d;
    logic [N_CLIENTS-1:0] timeout_q, timeout_d;
    logic [N_CLIENTS-1:0] timeout_set;
    logic                 overrun_set;
    logic                 frame_edge;
    logic                 vblnk_fall;
    logic [AW-1:0]        idx_a;

    assign frame_edge = vblnk & ~vblnk_q;
    assign vblnk_fall = ~vblnk & vblnk_q;
    // idx reaches N_CLIENTS only in the final SELECT cycle, where it is never used to index
    assign idx_a      = idx_q[AW-1:0];

    // Next-state logic for the sequencer, frame counter and sticky error flags
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        timer_d      = timer_q;
        frame_tick_d = 1'b0;
        frame_cnt_d  = frame_cnt_q;
        timeout_set  = '0;
        overrun_set  = 1'b0;

        if (frame_edge) begin
            frame_tick_d = 1'b1;
            frame_cnt_d  = frame_cnt_q + FRAME_W'(1);
        end else begin
            frame_tick_d = 1'b0;
        end

        if ((state_q != ST_IDLE) && (frame_edge || vblnk_fall)) begin
            overrun_set = 1'b1;
        end else begin
            overrun_set = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (frame_edge) begin
                    idx_d   = '0;
                    state_d = ST_SELECT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SELECT: begin
                if (idx_q == IDX_END) begin
                    idx_d   = '0;
                    state_d = ST_IDLE;
                end else if (client_en[idx_a]) begin
                    state_d = ST_START;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            ST_START: begin
                timer_d = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // done has priority over an expiring timer in the same cycle
                if (client_done[idx_a]) begin
                    idx_d   = idx_q + IW'(1);
                    state_d = ST_SELECT;
                end else if (timer_q == TMR_LAST) begin
                    timeout_set[idx_a] = 1'b1;
                    idx_d              = idx_q + IW'(1);
                    state_d            = ST_SELECT;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
                timer_d = '0;
            end
        endcase

        // a set in the same cycle as err_clr survives the clear
        if (err_clr) begin
            overrun_d = overrun_set;
            timeout_d = timeout_set;
        end else begin
            overrun_d = overrun_q | overrun_set;
            timeout_d = timeout_q | timeout_set;
        end
    end

    // State and status registers; vblnk_q resets high so a level already high is not a frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            timer_q      <= '0;
            vblnk_q      <= 1'b1;
            frame_tick_q <= 1'b0;
            frame_cnt_q  <= '0;
            overrun_q    <= 1'b0;
            timeout_q    <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            timer_q      <= timer_d;
            vblnk_q      <= vblnk;
            frame_tick_q <= frame_tick_d;
            frame_cnt_q  <= frame_cnt_d;
            overrun_q    <= overrun_d;
            timeout_q    <= timeout_d;
        end
    end

    // Output decode from registered state only
    always_comb begin
        client_start = '0;
        if (state_q == ST_START) begin
            client_start[idx_a] = 1'b1;
        end else begin
            client_start = '0;
        end
        if (state_q != ST_IDLE) begin
            busy          = 1'b1;
            active_client = idx_a;
        end else begin
            busy          = 1'b0;
            active_client = '0;
        end
    end

    assign frame_tick    = frame_tick_q;
    assign frame_cnt     = frame_cnt_q;
    assign overrun       = overrun_q;
    assign timeout_flags = timeout_q;

endmodule

// File: tb/tb_vblank_scheduler.sv
// Randomised bench for vblank_scheduler: a schedule-level reference model predicts
// every output per cycle; clients are emulated by responding to observed start pulses.
module tb_vblank_scheduler;

    localparam int N  = 4;
    localparam int T  = 16;
    localparam int FW = 4;
    localparam int MW = 256;

    logic       clk = 1'b0;
    logic       rst_n, vblnk, err_clr;
    logic [3:0] client_en, client_done, client_start, timeout_flags;
    logic [1:0] active_client;
    logic       busy, frame_tick, overrun;
    logic [3:0] frame_cnt;

    int total = 0;
    int bad   = 0;

    int         g_cnt;
    logic [3:0] g_flags;
    logic       g_ov;
    int         lat [4];
    int         obs_start [4];
    int         ticks_seen = 0;
    int         prev_cnt = 0;
    bit         saw_wrap = 1'b0;

    logic       e_busy  [MW];
    int         e_act   [MW];
    logic [3:0] e_start [MW];
    logic       e_wait  [MW];
    logic [3:0] set_to  [MW];
    logic       vb      [MW];
    logic [3:0] e_flags [MW+1];
    logic       e_ov    [MW+1];
    int         e_cnt   [MW+1];
    logic       e_tick  [MW+1];

    always #5 clk = ~clk;

    vblank_scheduler #(.N_CLIENTS(N), .TIMEOUT(T), .FRAME_W(FW)) dut (
        .clk(clk), .rst_n(rst_n), .vblnk(vblnk), .client_en(client_en),
        .client_done(client_done), .err_clr(err_clr), .client_start(client_start),
        .active_client(active_client), .busy(busy), .frame_tick(frame_tick),
        .frame_cnt(frame_cnt), .overrun(overrun), .timeout_flags(timeout_flags)
    );

    // One frame: vblnk rises in cycle 0 (was low before). vb_len_i<0 keeps vblnk high past the sequence.
    // r2>=0 adds a one-cycle vblnk pulse at that cycle. clr_mode: -1 none, -2 at first timeout, else cycle.
    task automatic run_frame(input logic [3:0] en, input int vb_len_i, input int r2,
                             input int clr_mode, input bit noise);
        int c, s, resp, w, vb_len, clr_cyc, first_to;
        int done_at [4];
        logic rise, fall;
        for (int k = 0; k < MW; k++) begin
            e_busy[k] = 1'b0; e_act[k] = 0; e_start[k] = 4'b0;
            e_wait[k] = 1'b0; set_to[k] = 4'b0; vb[k] = 1'b0;
        end
        first_to = -1;
        c = 1;
        for (int i = 0; i < N; i++) begin
            e_busy[c] = 1'b1; e_act[c] = i;
            if (!en[i]) begin
                c = c + 1;
            end else begin
                s = c + 1;
                e_start[s][i] = 1'b1; e_busy[s] = 1'b1; e_act[s] = i;
                resp = (lat[i] >= 1 && lat[i] <= T) ? lat[i] : T;
                for (int j = 1; j <= resp; j++) begin
                    e_busy[s+j] = 1'b1; e_act[s+j] = i; e_wait[s+j] = 1'b1;
                end
                if (!(lat[i] >= 1 && lat[i] <= T)) begin
                    set_to[s+T][i] = 1'b1;
                    if (first_to < 0) first_to = s + T;
                end
                c = s + resp + 1;
            end
        end
        e_busy[c] = 1'b1; e_act[c] = N % 4;
        vb_len = (vb_len_i < 0) ? c + 1 : vb_len_i;
        w = c + 3;
        if (vb_len + 3 > w) w = vb_len + 3;
        if (r2 + 3 > w) w = r2 + 3;
        for (int k = 0; k < w; k++) vb[k] = (k < vb_len) || (k == r2);
        clr_cyc = (clr_mode == -2) ? first_to : clr_mode;
        e_flags[0] = g_flags; e_ov[0] = g_ov; e_cnt[0] = g_cnt; e_tick[0] = 1'b0;
        for (int k = 0; k < w; k++) begin
            rise = vb[k] && (k == 0 || !vb[k-1]);
            fall = (k > 0) && !vb[k] && vb[k-1];
            e_tick[k+1]  = rise;
            e_cnt[k+1]   = (e_cnt[k] + (rise ? 1 : 0)) % 16;
            e_ov[k+1]    = (e_ov[k] && k != clr_cyc) || (e_busy[k] && (rise || fall));
            e_flags[k+1] = ((k == clr_cyc) ? 4'b0 : e_flags[k]) | set_to[k];
        end
        for (int i = 0; i < 4; i++) begin done_at[i] = -1; obs_start[i] = -1; end
        for (int k = 0; k < w; k++) begin
            @(negedge clk);
            total += 7;
            if (client_start !== e_start[k]) begin bad++; $display("FAIL start cyc=%0d got=%b exp=%b", k, client_start, e_start[k]); end
            if (busy !== e_busy[k]) begin bad++; $display("FAIL busy cyc=%0d got=%b exp=%b", k, busy, e_busy[k]); end
            if (active_client !== 2'(e_act[k])) begin bad++; $display("FAIL active cyc=%0d got=%0d exp=%0d", k, active_client, e_act[k]); end
            if (frame_tick !== e_tick[k]) begin bad++; $display("FAIL tick cyc=%0d got=%b exp=%b", k, frame_tick, e_tick[k]); end
            if (frame_cnt !== 4'(e_cnt[k])) begin bad++; $display("FAIL cnt cyc=%0d got=%0d exp=%0d", k, frame_cnt, e_cnt[k]); end
            if (overrun !== e_ov[k]) begin bad++; $display("FAIL overrun cyc=%0d got=%b exp=%b", k, overrun, e_ov[k]); end
            if (timeout_flags !== e_flags[k]) begin bad++; $display("FAIL flags cyc=%0d got=%b exp=%b", k, timeout_flags, e_flags[k]); end
            if (frame_tick === 1'b1) ticks_seen++;
            if (prev_cnt == 15 && frame_cnt === 4'd0) saw_wrap = 1'b1;
            prev_cnt = int'(frame_cnt);
            for (int i = 0; i < 4; i++) begin
                if (client_start[i] === 1'b1) begin
                    obs_start[i] = k;
                    if (lat[i] > 0) done_at[i] = k + lat[i];
                end
            end
            vblnk     = vb[k];
            client_en = en;
            err_clr   = (k == clr_cyc);
            for (int i = 0; i < 4; i++) begin
                client_done[i] = (k == done_at[i]) ||
                                 (noise && !(e_wait[k] && e_act[k] == i) && $urandom_range(0, 3) == 0);
            end
        end
        g_flags = e_flags[w]; g_ov = e_ov[w]; g_cnt = e_cnt[w];
    endtask

    task automatic clear_errs();
        @(negedge clk); err_clr = 1'b1; client_done = 4'b0; vblnk = 1'b0;
        @(negedge clk); err_clr = 1'b0;
        g_flags = 4'b0; g_ov = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; vblnk = 1'b1; client_en = 4'b0; client_done = 4'b0; err_clr = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        total += 4;
        if (client_start !== 4'b0 || busy !== 1'b0) begin bad++; $display("FAIL rst_start_busy got=%b/%b exp=0000/0", client_start, busy); end
        if (frame_tick !== 1'b0 || frame_cnt !== 4'd0) begin bad++; $display("FAIL rst_tick_cnt got=%b/%0d exp=0/0", frame_tick, frame_cnt); end
        if (overrun !== 1'b0 || timeout_flags !== 4'b0) begin bad++; $display("FAIL rst_errs got=%b/%b exp=0/0000", overrun, timeout_flags); end
        if (active_client !== 2'd0) begin bad++; $display("FAIL rst_active got=%0d exp=0", active_client); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            total++;
            if (frame_tick !== 1'b0 || busy !== 1'b0 || frame_cnt !== 4'd0) begin
                bad++; $display("FAIL rel_high got tick=%b busy=%b cnt=%0d exp=0/0/0", frame_tick, busy, frame_cnt);
            end
        end
        vblnk = 1'b0;
        @(negedge clk);
        total++;
        if (frame_tick !== 1'b0 || frame_cnt !== 4'd0) begin bad++; $display("FAIL rel_fall got tick=%b cnt=%0d exp=0/0", frame_tick, frame_cnt); end
        g_cnt = 0; g_flags = 4'b0; g_ov = 1'b0;
    endtask

    task automatic test_basic();
        for (int i = 0; i < 4; i++) lat[i] = 10;
        run_frame(4'b1111, -1, -1, -1, 1'b0);
        for (int i = 1; i < 4; i++) begin
            total++;
            if (obs_start[i] - obs_start[i-1] !== 12) begin
                bad++; $display("FAIL basic_gap%0d got=%0d exp=12", i, obs_start[i] - obs_start[i-1]);
            end
        end
        total++;
        if (frame_cnt !== 4'd1) begin bad++; $display("FAIL basic_cnt got=%0d exp=1", frame_cnt); end
    endtask

    task automatic test_mask();
        for (int i = 0; i < 4; i++) lat[i] = int'($urandom_range(1, 5));
        run_frame(4'b1010, -1, -1, -1, 1'b1);
        total += 2;
        if (obs_start[0] !== -1 || obs_start[2] !== -1) begin bad++; $display("FAIL mask_skip got=%0d/%0d exp=-1/-1", obs_start[0], obs_start[2]); end
        if (obs_start[1] !== 3) begin bad++; $display("FAIL mask_first got=%0d exp=3", obs_start[1]); end
    endtask

    task automatic test_timeout();
        lat[0] = 3; lat[1] = 4; lat[2] = 0; lat[3] = 2;
        run_frame(4'b1111, -1, -1, -1, 1'b0);
        total += 2;
        if (timeout_flags !== 4'b0100) begin bad++; $display("FAIL to_flags got=%b exp=0100", timeout_flags); end
        if (obs_start[3] - obs_start[2] !== T + 2) begin bad++; $display("FAIL to_next got=%0d exp=%0d", obs_start[3] - obs_start[2], T + 2); end
        clear_errs();
        @(negedge clk);
        total++;
        if (timeout_flags !== 4'b0) begin bad++; $display("FAIL to_clear got=%b exp=0000", timeout_flags); end
    endtask

    task automatic test_timeout_coincident();
        lat[0] = 2; lat[1] = 2; lat[2] = T; lat[3] = 2;
        run_frame(4'b1111, -1, -1, -1, 1'b0);
        total++;
        if (timeout_flags !== 4'b0) begin bad++; $display("FAIL to_coinc got=%b exp=0000", timeout_flags); end
    endtask

    task automatic test_clr_collision();
        lat[0] = 1; lat[1] = 1; lat[2] = 0; lat[3] = 1;
        run_frame(4'b1111, -1, -1, -2, 1'b0);
        total++;
        if (timeout_flags !== 4'b0100) begin bad++; $display("FAIL clr_vs_set got=%b exp=0100", timeout_flags); end
        clear_errs();
    endtask

    task automatic test_overrun();
        int cnt0, vbl;
        cnt0 = g_cnt;
        lat[0] = int'($urandom_range(2, 6)); lat[1] = int'($urandom_range(6, 10));
        lat[2] = int'($urandom_range(2, 6)); lat[3] = int'($urandom_range(2, 6));
        vbl = lat[0] + 6;
        run_frame(4'b1111, vbl, vbl + 3, -1, 1'b0);
        total += 3;
        if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_flag got=%b exp=1", overrun); end
        if (obs_start[3] < 0 || busy !== 1'b0) begin bad++; $display("FAIL ovr_complete got start3=%0d busy=%b exp=>=0/0", obs_start[3], busy); end
        if (frame_cnt !== 4'((cnt0 + 2) % 16)) begin bad++; $display("FAIL ovr_cnt got=%0d exp=%0d", frame_cnt, (cnt0 + 2) % 16); end
        clear_errs();
    endtask

    task automatic test_random();
        for (int it = 0; it < 10; it++) begin
            for (int i = 0; i < 4; i++) lat[i] = int'($urandom_range(0, T));
            run_frame(4'($urandom), int'($urandom_range(1, 60)), -1,
                      ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, 50)), 1'b1);
        end
        clear_errs();
    endtask

    task automatic test_reset_mid();
        @(negedge clk); vblnk = 1'b1; client_en = 4'b1111; client_done = 4'b0;
        @(negedge clk); vblnk = 1'b0;
        repeat (5) @(negedge clk);
        total++;
        if (busy !== 1'b1 || active_client !== 2'd0) begin bad++; $display("FAIL mid_pre got busy=%b act=%0d exp=1/0", busy, active_client); end
        #2 rst_n = 1'b0;
        #1;
        total += 2;
        if (busy !== 1'b0 || client_start !== 4'b0 || frame_tick !== 1'b0 || active_client !== 2'd0) begin
            bad++; $display("FAIL mid_async got busy=%b start=%b tick=%b act=%0d exp=0", busy, client_start, frame_tick, active_client);
        end
        if (frame_cnt !== 4'd0 || overrun !== 1'b0 || timeout_flags !== 4'b0) begin
            bad++; $display("FAIL mid_errs got cnt=%0d ovr=%b flags=%b exp=0", frame_cnt, overrun, timeout_flags);
        end
        @(negedge clk);
        total++;
        if (client_start !== 4'b0 || busy !== 1'b0) begin bad++; $display("FAIL mid_hold got start=%b busy=%b exp=0", client_start, busy); end
        rst_n = 1'b1;
        g_cnt = 0; g_flags = 4'b0; g_ov = 1'b0;
        for (int i = 0; i < 4; i++) lat[i] = int'($urandom_range(1, 8));
        run_frame(4'b1111, -1, -1, -1, 1'b0);
        total++;
        if (obs_start[0] < 0) begin bad++; $display("FAIL mid_restart got=%0d exp=>=0", obs_start[0]); end
    endtask

    task automatic test_wrap();
        int t0;
        t0 = ticks_seen;
        saw_wrap = 1'b0;
        for (int f = 0; f < 17; f++) run_frame(4'($urandom_range(0, 1)), -1, -1, -1, 1'b0);
        total += 2;
        if (ticks_seen - t0 !== 17) begin bad++; $display("FAIL wrap_ticks got=%0d exp=17", ticks_seen - t0); end
        if (saw_wrap !== 1'b1) begin bad++; $display("FAIL wrap_seen got=%b exp=1", saw_wrap); end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) lat[i] = 1;
        test_reset();
        test_basic();
        test_mask();
        test_timeout();
        test_timeout_coincident();
        test_clr_collision();
        test_overrun();
        test_random();
        test_reset_mid();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vblank_scheduler.md
# vblank_scheduler

Frame-level controller that sequences the game-logic update blocks inside the vertical blanking interval of the VGA timing generator. On each rising edge of `vblnk` it starts each enabled client in index order with a one-cycle start pulse, waits for each client's done, and enforces a per-client timeout. It sits between the VGA timing controller and the update modules (bird physics, pipe scroller, collision, score). It reports the frame count, sticky overrun and timeout errors, and a busy flag for the draw path.

## Interface
- `N_CLIENTS`, 4: number of sequenced clients, 1..16.
- `TIMEOUT`, 4096: maximum WAIT cycles per client, ≥2.
- `FRAME_W`, 16: frame counter width.

- `clk` in 1: pixel clock, the same clock as the VGA timing controller.
- `rst_n` in 1: reset, asynchronous, active-low.
- `vblnk` in 1: vertical blank from the VGA timing controller, synchronous to `clk`.
- `client_en` in N_CLIENTS: per-client enable, sampled in SELECT.
- `client_done` in N_CLIENTS: per-client completion, one-cycle or level.
- `err_clr` in 1: clears the sticky error flags.
- `client_start` out N_CLIENTS: one-hot, one-cycle start pulse.
- `active_client` out $clog2(N_CLIENTS) (min 1): index currently selected or running.
- `busy` out 1: a sequence is in progress.
- `frame_tick` out 1: one-cycle pulse at each detected frame boundary.
- `frame_cnt` out FRAME_W: frames detected since reset, wraps.
- `overrun` out 1: sticky; a sequence was still running when video resumed or a new frame began.
- `timeout_flags` out N_CLIENTS: sticky; client i hit the timeout.

## Operation
- **Edge detector.**
  - `vblnk_q` is a register of `vblnk`.
  - Frame edge = `vblnk & ~vblnk_q`.
  - `vblnk_q` resets to 1, so a `vblnk` that is already high at reset release produces no frame.
- **IDLE.**
  - On a frame edge: `frame_tick`<=1, `frame_cnt`<=`frame_cnt`+1 (mod 2^FRAME_W), idx<=0, go to SELECT.
- **SELECT.**
  - If idx==N_CLIENTS, go to IDLE.
  - Else if `client_en[idx]`, go to START.
  - Else idx<=idx+1 and stay in SELECT. Each skipped client costs one cycle.
- **START.**
  - `client_start[idx]`=1 for this cycle only.
  - Timer<=0, go to WAIT.
- **WAIT.**
  - If `client_done[idx]`: idx<=idx+1, go to SELECT.
  - Else if timer==TIMEOUT-1: `timeout_flags[idx]`<=1, idx<=idx+1, go to SELECT.
  - Else timer<=timer+1.
  - Done and timeout in the same cycle: done wins and no flag is set.
- **Done handling.**
  - Done from non-active clients is ignored.
  - Done during the START cycle is ignored. A client may assert done at the earliest in its first WAIT cycle.
- **Overrun conditions** (sequence continues in both cases):
  - A falling edge of `vblnk` (`~vblnk & vblnk_q`) while state≠IDLE sets `overrun`.
  - A frame edge while state≠IDLE also sets `overrun`, pulses `frame_tick` and increments `frame_cnt`, but does not restart or queue a sequence; that frame's updates are skipped.
- **Error clear.**
  - `err_clr` clears `overrun` and all `timeout_flags`.
  - A set condition in the same cycle wins over clear.
- **Output definitions.**
  - `busy` = (state≠IDLE).
  - `active_client` = idx, held at 0 in IDLE.
  - Timer width is $clog2(TIMEOUT).
- **Reset.**
  - While `rst_n`=0, all outputs are 0: `client_start`, `busy`, `frame_tick`, `frame_cnt`, `overrun`, `timeout_flags`, `active_client`.
  - Internal state: state=IDLE, idx=0, timer=0, `vblnk_q`=1.
  - Reset asserted mid-sequence aborts immediately; no further start pulses are issued.

## Timing
- All outputs are registered or decoded from registered state; there is no combinational input-to-output path.
- Clock edge k is the first edge at which `vblnk`=1 with `vblnk_q`=0.
  - Cycle k+1: `frame_tick`=1, `busy`=1, state SELECT.
  - Cycle k+2: `client_start[0]`=1, if client 0 is enabled.
- `client_done[i]` sampled high at edge m:
  - cycle m+1: SELECT;
  - cycle m+2: next enabled client's start, if it is adjacent.
- Each disabled client inserts one SELECT cycle.
- Timeout: a client whose start is in cycle s and that never asserts done gets its flag set at the edge ending cycle s+TIMEOUT, i.e. TIMEOUT WAIT cycles.
- After the last client completes: one SELECT cycle with idx==N_CLIENTS, then `busy`=0.
- Minimum sequence with all 4 clients enabled and done on the first WAIT cycle: `busy` high for 1+4×3 = 13 cycles.

## Test plan
- **Basic sequence.** Reset, all 4 enabled, each client asserts done 10 cycles after its start, then `vblnk` 0→1.
  - `frame_tick` pulses once, `frame_cnt`=1.
  - Starts occur in order 0,1,2,3, with consecutive starts 12 cycles apart.
  - `busy` deasserts; no flags set.
- **Enable mask.** `client_en`=4'b1010.
  - Only `client_start[1]` and `client_start[3]` pulse.
  - `active_client` skips 0 and 2 with one SELECT cycle each.
- **Timeout.** TIMEOUT=16, client 2 never responds.
  - `timeout_flags`=4'b0100 exactly 16 cycles after `client_start[2]`.
  - Client 3 is then started.
  - `err_clr` returns the flags to 0.
  - Variant: done coincident with the last timer count sets no flag.
- **Overrun.**
  - `vblnk` falls while client 1 is in WAIT: `overrun`=1 and the sequence completes.
  - A second frame edge while busy: `frame_cnt` increments, no restart, `overrun` stays 1.
- **Reset edge cases.**
  - Release `rst_n` with `vblnk`=1: no `frame_tick` until the next 0→1.
  - Assert `rst_n`=0 mid-WAIT: all outputs 0 asynchronously, and the next frame starts from client 0.
- **Wrap.** FRAME_W=4, 16 frames: `frame_cnt` goes 15→0, and `frame_tick` count equals the number of frames driven.
